// File: rtl/mem_access_pkg.sv
// Shared constants for the rv32 memory-stage access controller: opcodes,
// funct3 codes, FSM state encoding, error causes and the byte-enable rule.
package mem_access_pkg;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    CAUSE_NONE     = 2'd0,
    CAUSE_ILLEGAL  = 2'd1,
    CAUSE_MISALIGN = 2'd2,
    CAUSE_TIMEOUT  = 2'd3
  } cause_t;

  // funct3[1:0] carries the access size for both loads and stores.
  function automatic logic [3:0] byte_en(input logic [2:0] f3, input logic [1:0] a);
    logic [3:0] be;
    case (f3[1:0])
      2'b00:   be = 4'b0001 << a;
      2'b01:   be = a[1] ? 4'b1100 : 4'b0011;
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

endpackage

// File: rtl/mem_load_align.sv
// Combinational load alignment: selects the addressed byte/halfword lane of
// the raw read word and sign- or zero-extends it according to funct3.
module mem_load_align
  import mem_access_pkg::*;
(
  input  logic [31:0] i_rdata,
  input  logic [1:0]  i_addr_lo,
  input  logic [2:0]  i_funct3,
  output logic [31:0] o_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  assign w_byte = i_rdata[{i_addr_lo, 3'b000} +: 8];
  assign w_half = i_addr_lo[1] ? i_rdata[31:16] : i_rdata[15:0];

  always_comb begin
    o_data = 32'h0;
    case (i_funct3)
      F3_B:    o_data = {{24{w_byte[7]}}, w_byte};
      F3_H:    o_data = {{16{w_half[15]}}, w_half};
      F3_W:    o_data = i_rdata;
      F3_BU:   o_data = {24'h0, w_byte};
      F3_HU:   o_data = {16'h0, w_half};
      default: o_data = 32'h0;
    endcase
  end

endmodule

// File: rtl/mem_access_ctl.sv
// Memory-stage access controller: decodes loads/stores, runs a req/ack data
// port with a bus timeout, and hands results to writeback. MISALIGN_TRAP_EN
// enables trapping of misaligned halfword/word accesses.
module mem_access_ctl
  import mem_access_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       in_instr,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic [31:0]       in_wdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [3:0]        mem_be,
  output logic [31:0]       mem_wdata,
  input  logic              mem_ack,
  input  logic [31:0]       mem_rdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_instr,
  output logic [31:0]       out_rdata,
  output logic [1:0]        out_cause,
  output logic [1:0]        dbg_state
);

  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(TIMEOUT_CYC);

  // Handshakes: a transfer happens on a rising edge where valid && ready;
  // valid never waits on ready, and payload is held stable while valid && !ready.

  state_t            r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_mem_req;
  logic              r_mem_we;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [3:0]        r_mem_be;
  logic [31:0]       r_mem_wdata;
  logic              r_out_valid;
  logic [31:0]       r_out_instr;
  logic [31:0]       r_out_rdata;
  cause_t            r_cause;
  logic [2:0]        r_funct3;
  logic [1:0]        r_addr_lo;

  logic [6:0]  w_opcode;
  logic [2:0]  w_funct3;
  logic        w_legal_load;
  logic        w_legal_store;
  logic        w_illegal;
  logic        w_misalign;
  logic        w_go_mem;
  logic        w_accept;
  logic [31:0] w_lane_wdata;
  logic [31:0] w_load_data;

  assign w_opcode = in_instr[6:0];
  assign w_funct3 = in_instr[14:12];

  assign w_legal_load  = (w_opcode == OP_LOAD) &&
                         (w_funct3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU});
  assign w_legal_store = (w_opcode == OP_STORE) && (w_funct3 inside {F3_B, F3_H, F3_W});
  assign w_illegal     = ((w_opcode == OP_LOAD) && !w_legal_load) ||
                         ((w_opcode == OP_STORE) && !w_legal_store);

`ifdef MISALIGN_TRAP_EN
  assign w_misalign = (w_legal_load || w_legal_store) &&
                      (((w_funct3[1:0] == 2'b01) && in_addr[0]) ||
                       ((w_funct3[1:0] == 2'b10) && (in_addr[1:0] != 2'b00)));
`else
  assign w_misalign = 1'b0;
`endif

  assign w_go_mem = (w_legal_load || w_legal_store) && !w_misalign;
  assign w_accept = in_valid && in_ready;

  always_comb begin
    w_lane_wdata = in_wdata;
    case (w_funct3[1:0])
      2'b00:   w_lane_wdata = {4{in_wdata[7:0]}};
      2'b01:   w_lane_wdata = {2{in_wdata[15:0]}};
      default: w_lane_wdata = in_wdata;
    endcase
  end

  always_comb begin
    in_ready = 1'b0;
    case (r_state)
      ST_IDLE:   in_ready = 1'b1;
      ST_RESP:   in_ready = out_ready;
      default:   in_ready = 1'b0;
    endcase
  end

  mem_load_align u_align (
    .i_rdata   (mem_rdata),
    .i_addr_lo (r_addr_lo),
    .i_funct3  (r_funct3),
    .o_data    (w_load_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_be    <= 4'h0;
      r_mem_wdata <= 32'h0;
      r_out_valid <= 1'b0;
      r_out_instr <= 32'h0;
      r_out_rdata <= 32'h0;
      r_cause     <= CAUSE_NONE;
      r_funct3    <= 3'h0;
      r_addr_lo   <= 2'h0;
    end else begin
      case (r_state)
        ST_IDLE, ST_RESP: begin
          if ((r_state == ST_RESP) && out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= ST_IDLE;
          end
          // An accept in RESP overrides the drop to IDLE above.
          if (w_accept) begin
            r_out_instr <= in_instr;
            r_funct3    <= w_funct3;
            r_addr_lo   <= in_addr[1:0];
            r_cnt       <= '0;
            r_out_rdata <= 32'h0;
            if (w_go_mem) begin
              r_state     <= ST_ACCESS;
              r_mem_req   <= 1'b1;
              r_mem_we    <= w_legal_store;
              r_mem_addr  <= in_addr & ~ADDR_W'(3);
              r_mem_be    <= byte_en(w_funct3, in_addr[1:0]);
              r_mem_wdata <= w_lane_wdata;
              r_out_valid <= 1'b0;
              r_cause     <= CAUSE_NONE;
            end else begin
              r_state     <= ST_RESP;
              r_out_valid <= 1'b1;
              r_cause     <= w_illegal  ? CAUSE_ILLEGAL  :
                             w_misalign ? CAUSE_MISALIGN : CAUSE_NONE;
            end
          end
        end
        ST_ACCESS: begin
          if (mem_ack) begin
            r_mem_req   <= 1'b0;
            r_state     <= ST_RESP;
            r_out_valid <= 1'b1;
            r_out_rdata <= r_mem_we ? 32'h0 : w_load_data;
            r_cause     <= CAUSE_NONE;
          end else if (r_cnt == CNT_LAST) begin
            r_mem_req   <= 1'b0;
            r_state     <= ST_RESP;
            r_out_valid <= 1'b1;
            r_out_rdata <= 32'h0;
            r_cause     <= CAUSE_TIMEOUT;
            r_cnt       <= CNT_FULL;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign mem_req   = r_mem_req;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_be    = r_mem_be;
  assign mem_wdata = r_mem_wdata;
  assign out_valid = r_out_valid;
  assign out_instr = r_out_instr;
  assign out_rdata = r_out_rdata;
  assign out_cause = r_cause;
  assign dbg_state = r_state;

endmodule

// File: doc/mem_access_ctl.md
# mem_access_ctl

Memory-stage access controller for the rv32 pipeline; the parametrised successor to the store-only write-enable decode. It decodes loads and stores, drives a request/acknowledge data-memory port with byte enables and lane-replicated write data, and waits for memory that may take several cycles. It aligns and sign/zero-extends load data, applies a bus timeout, and forwards the instruction with its result and error cause to writeback through a valid/ready handshake.

## Interface
- ADDR_W, 32: data-memory byte-address width; must be at least 2.
- TIMEOUT_CYC, 16: maximum cycles `mem_req` stays high without `mem_ack`; must be at least 1.
- clk  in  1  clock, rising edge.
- rst  in  1  reset, synchronous, active-high.
- in_valid  in  1  upstream instruction valid.
- in_ready  out  1  controller can accept an instruction.
- in_instr  in  32  instruction.
- in_addr  in  ADDR_W  effective byte address (rs1+imm).
- in_wdata  in  32  store data (rs2).
- mem_req  out  1  memory request.
- mem_we  out  1  1 = store, 0 = load.
- mem_addr  out  ADDR_W  word-aligned address, with bits [1:0] = 0.
- mem_be  out  4  byte enables.
- mem_wdata  out  32  lane-replicated store data.
- mem_ack  in  1  request complete; `mem_rdata` is valid in the same cycle for loads.
- mem_rdata  in  32  raw read word.
- out_valid  out  1  result valid to writeback.
- out_ready  in  1  writeback accepts.
- out_instr  out  32  forwarded instruction.
- out_rdata  out  32  extended load data; 0 for non-loads and on error.
- out_cause  out  2  0 = none, 1 = illegal funct3, 2 = misaligned, 3 = timeout.

## Operation
- FSM states and transitions:
  - IDLE: moves on accept (`in_valid && in_ready`).
  - ACCESS: entered for a legal load or store.
  - RESP: entered directly for non-memory instructions, illegal funct3 or trapped misalignment.
- `in_ready` is 1 in IDLE, equals `out_ready` in RESP, and is 0 in ACCESS.
  - A RESP→RESP or RESP→ACCESS back-to-back accept is legal.
- Decoded instructions:
  - opcode 0000011: LB 000, LH 001, LW 010, LBU 100, LHU 101.
  - opcode 0100011: SB 000, SH 001, SW 010.
  - Any other funct3 under these two opcodes gives cause 1 and no memory request.
- Byte enables and write data:
  - SB: `mem_be` = 0001 << addr[1:0]; `mem_wdata` = {4{wdata[7:0]}}.
  - SH: `mem_be` = 0011 << {addr[1],0}; `mem_wdata` = {2{wdata[15:0]}}.
  - SW: `mem_be` = 1111; `mem_wdata` = wdata.
  - Loads use the same byte-enable rule.
- ACCESS:
  - `mem_req`, `mem_we`, `mem_addr`, `mem_be` and `mem_wdata` are registered and held stable until the `mem_ack` cycle.
  - On ack: capture the extracted and extended read data, go to RESP.
- Timeout:
  - A counter of width $clog2(TIMEOUT_CYC+1) increments each ACCESS cycle without ack.
  - When it reaches TIMEOUT_CYC: drop `mem_req`, go to RESP with cause 3 and `out_rdata` = 0.
  - Ack in the same cycle as the timeout: ack wins.
- `mem_ack` is ignored outside ACCESS.
- RESP: `out_valid` = 1; the instruction, data and cause are held until `out_ready`.

## Timing
- Reset values:
  - state IDLE.
  - `mem_req`, `mem_we`, `mem_addr`, `mem_be`, `mem_wdata` = 0.
  - `out_valid`, `out_instr`, `out_rdata`, `out_cause` = 0.
  - Counter = 0.
- `rst` has priority over everything. Asserted mid-ACCESS, it drops `mem_req` the next cycle and discards the pending result.
- Non-memory or faulting instruction: accepted at edge N, `out_valid` = 1 from edge N+1.
- Load/store: accepted at edge N, `mem_req` = 1 from edge N+1; ack sampled at edge M gives `out_valid` = 1 from edge M+1 and `mem_req` = 0.
- Minimum memory-instruction latency is 2 cycles (ack in the first request cycle).

## Configuration
- MISALIGN_TRAP_EN defined:
  - Misaligned access is LH/LHU/SH with addr[0] = 1, or LW/SW with addr[1:0] ≠ 0.
  - It issues no request and goes to RESP with cause 2.
- MISALIGN_TRAP_EN undefined:
  - Low address bits are ignored: a halfword uses lane addr[1], a word uses all lanes.
  - The access proceeds; cause 2 is never produced.

## Structure
- Package `mem_access_pkg` holds:
  - opcode and funct3 constants.
  - the FSM state enum (IDLE/ACCESS/RESP).
  - cause codes.
- Sub-module `mem_load_align` is combinational: (rdata, addr[1:0], funct3) → extended 32-bit data.

## Test plan
- LW, addr 0x100, ack after 3 cycles, rdata 0xDEADBEEF → `mem_be` 1111, `mem_addr` 0x100, `out_rdata` 0xDEADBEEF, cause 0.
- LB, addr 0x103, rdata 0x80112233 → `mem_be` 1000, `out_rdata` 0xFFFFFF80; LBU at the same address → 0x00000080.
- SH, addr 0x22, wdata 0x1234ABCD, ack immediate → `mem_we` 1, `mem_be` 1100, `mem_wdata` 0xABCDABCD, `out_valid` 2 cycles after accept.
- SW, no ack, TIMEOUT_CYC = 16 → `mem_req` high exactly 16 cycles, then cause 3; ack arriving in cycle 16 instead → cause 0.
- LW, addr 0x102 → with MISALIGN_TRAP_EN: no `mem_req`, cause 2; without: request to 0x100, `mem_be` 1111.
- ADD, then SB with `out_ready` held 0 for 4 cycles → ADD held in RESP, `in_ready` 0, SB request issued only after ADD is consumed.
